// File: rtl/ysyx_23060124_wbu_if.sv
// EXU->WBU retire handshake: valid/ready plus the latched instruction payload.
// master = EXU side (drives payload/valid), slave = WBU side (drives ready).
interface ysyx_23060124_wbu_if;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] res;
    logic [4:0]  rd_addr;
    logic        wen;
    logic [11:0] csr_addr;
    logic        csr_wen;
    logic        brch;
    logic        jal;
    logic        jalr;
    logic        mret;
    logic        ecall;
    logic [31:0] mepc;
    logic [31:0] mtvec;

    modport master (
        output valid, pc, pc_next, res, rd_addr, wen,
        output csr_addr, csr_wen, brch, jal, jalr, mret, ecall,
        output mepc, mtvec,
        input  ready
    );

    modport slave (
        input  valid, pc, pc_next, res, rd_addr, wen,
        input  csr_addr, csr_wen, brch, jal, jalr, mret, ecall,
        input  mepc, mtvec,
        output ready
    );
endinterface

// File: rtl/ysyx_23060124_wbu.sv
// Write-back unit: retires one instruction per handshake, drives GPR/CSR
// write ports, raises and holds control-flow redirects, counts instret.
// Ports: clock/reset (async, active-low), up (retire handshake, slave),
// GPR/CSR write ports, ecall commit, redirect to IFU, flush, commit, instret.
module ysyx_23060124_wbu #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    ysyx_23060124_wbu_if.slave         up,
    output logic                       o_rf_wen,
    output logic [4:0]                 o_rf_waddr,
    output logic [31:0]                o_rf_wdata,
    output logic                       o_csr_wen,
    output logic [11:0]                o_csr_waddr,
    output logic [31:0]                o_csr_wdata,
    output logic                       o_ecall_commit,
    output logic [31:0]                o_epc,
    output logic                       o_redirect_valid,
    output logic [31:0]                o_redirect_pc,
    input  logic                       i_ifu_ready,
    output logic                       o_flush,
    output logic                       o_commit,
    output logic [31:0]                o_commit_pc,
    output logic [63:0]                o_instret
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT
    } state_e;

    state_e      state_q;
    logic        rf_wen_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        csr_wen_q;
    logic [11:0] csr_waddr_q;
    logic [31:0] csr_wdata_q;
    logic        ecall_q;
    logic [31:0] epc_q;
    logic        redir_q;
    logic [31:0] redir_pc_q;
    logic        flush_q;
    logic        commit_q;
    logic [31:0] commit_pc_q;
    logic [63:0] instret_q;

    logic        ready;
    logic        accept;
    logic        need_redir_d;
    logic [31:0] target_d;
    logic [31:0] rf_wdata_d;
    logic        rf_wen_d;

    // In COMMIT, redir_q mirrors the latched redirect flags.
    always_comb begin
        ready = 1'b0;
        unique case (state_q)
            IDLE:     ready = 1'b1;
            COMMIT:   ready = ~redir_q;
            REDIRECT: ready = 1'b0;
            default:  ready = 1'b0;
        endcase
    end

    assign up.ready = ready;
    assign accept   = up.valid & ready;

    assign need_redir_d = up.ecall | up.mret | up.jal
                        | up.jalr | up.brch;

    // ecall outranks mret when both flags are set.
    always_comb begin
        target_d = up.pc_next;
        if (up.ecall)
            target_d = up.mtvec;
        else if (up.mret)
            target_d = up.mepc;
    end

    assign rf_wdata_d = (up.jal | up.jalr) ? up.pc + 32'd4 : up.res;
    assign rf_wen_d   = up.wen & (up.rd_addr != 5'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= 5'd0;
            rf_wdata_q  <= 32'd0;
            csr_wen_q   <= 1'b0;
            csr_waddr_q <= 12'd0;
            csr_wdata_q <= 32'd0;
            ecall_q     <= 1'b0;
            epc_q       <= 32'd0;
            redir_q     <= 1'b0;
            redir_pc_q  <= RESET_PC;
            flush_q     <= 1'b0;
            commit_q    <= 1'b0;
            commit_pc_q <= 32'd0;
            instret_q   <= 64'd0;
        end else begin
            // Strobes live for the single COMMIT cycle only.
            rf_wen_q  <= 1'b0;
            csr_wen_q <= 1'b0;
            ecall_q   <= 1'b0;
            flush_q   <= 1'b0;
            commit_q  <= 1'b0;
            if (accept) begin
                state_q     <= COMMIT;
                rf_wen_q    <= rf_wen_d;
                rf_waddr_q  <= up.rd_addr;
                rf_wdata_q  <= rf_wdata_d;
                csr_wen_q   <= up.csr_wen;
                csr_waddr_q <= up.csr_addr;
                csr_wdata_q <= up.res;
                ecall_q     <= up.ecall;
                epc_q       <= up.pc;
                commit_q    <= 1'b1;
                commit_pc_q <= up.pc;
                flush_q     <= need_redir_d;
                redir_q     <= need_redir_d;
                if (need_redir_d)
                    redir_pc_q <= target_d;
                instret_q   <= instret_q + 64'd1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    COMMIT: begin
                        if (redir_q && !i_ifu_ready) begin
                            state_q <= REDIRECT;
                        end else begin
                            state_q <= IDLE;
                            redir_q <= 1'b0;
                        end
                    end
                    REDIRECT: begin
                        if (i_ifu_ready) begin
                            state_q <= IDLE;
                            redir_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        redir_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rf_wen         = rf_wen_q;
    assign o_rf_waddr       = rf_waddr_q;
    assign o_rf_wdata       = rf_wdata_q;
    assign o_csr_wen        = csr_wen_q;
    assign o_csr_waddr      = csr_waddr_q;
    assign o_csr_wdata      = csr_wdata_q;
    assign o_ecall_commit   = ecall_q;
    assign o_epc            = epc_q;
    assign o_redirect_valid = redir_q;
    assign o_redirect_pc    = redir_pc_q;
    assign o_flush          = flush_q;
    assign o_commit         = commit_q;
    assign o_commit_pc      = commit_pc_q;
    assign o_instret        = instret_q;

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Directed bench for ysyx_23060124_wbu: vector table for single retires,
// hand sequences for back-to-back, held redirect and reset mid-redirect.
module tb_ysyx_23060124_wbu;

    logic        clock;
    logic        reset;
    logic        o_rf_wen;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata;
    logic        o_csr_wen;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata;
    logic        o_ecall_commit;
    logic [31:0] o_epc;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        i_ifu_ready;
    logic        o_flush;
    logic        o_commit;
    logic [31:0] o_commit_pc;
    logic [63:0] o_instret;

    ysyx_23060124_wbu_if u_if ();

    ysyx_23060124_wbu dut (
        .clock           (clock),
        .reset           (reset),
        .up              (u_if),
        .o_rf_wen        (o_rf_wen),
        .o_rf_waddr      (o_rf_waddr),
        .o_rf_wdata      (o_rf_wdata),
        .o_csr_wen       (o_csr_wen),
        .o_csr_waddr     (o_csr_waddr),
        .o_csr_wdata     (o_csr_wdata),
        .o_ecall_commit  (o_ecall_commit),
        .o_epc           (o_epc),
        .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc   (o_redirect_pc),
        .i_ifu_ready     (i_ifu_ready),
        .o_flush         (o_flush),
        .o_commit        (o_commit),
        .o_commit_pc     (o_commit_pc),
        .o_instret       (o_instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] res;
        logic [31:0] mepc;
        logic [31:0] mtvec;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic        wen;
        logic        cwen;
        logic        brch;
        logic        jal;
        logic        jalr;
        logic        mret;
        logic        ecall;
        logic        e_rfwen;
        logic [31:0] e_wdata;
        logic        e_cwen;
        logic        e_ecall;
        logic        e_redir;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t        vecs [7];
    int          n_chk;
    int          n_err;
    logic [63:0] exp_instret;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        u_if.valid    = 1'b0;
        u_if.pc       = 32'd0;
        u_if.pc_next  = 32'd0;
        u_if.res      = 32'd0;
        u_if.rd_addr  = 5'd0;
        u_if.wen      = 1'b0;
        u_if.csr_addr = 12'd0;
        u_if.csr_wen  = 1'b0;
        u_if.brch     = 1'b0;
        u_if.jal      = 1'b0;
        u_if.jalr     = 1'b0;
        u_if.mret     = 1'b0;
        u_if.ecall    = 1'b0;
        u_if.mepc     = 32'd0;
        u_if.mtvec    = 32'd0;
    endtask

    task automatic drive_alu(input logic [31:0] pc,
                             input logic [4:0] rd,
                             input logic [31:0] res);
        clear_in();
        u_if.valid   = 1'b1;
        u_if.pc      = pc;
        u_if.rd_addr = rd;
        u_if.wen     = 1'b1;
        u_if.res     = res;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        exp_instret = 64'd0;
        // pc, pc_next, res, mepc, mtvec, rd, csr,
        // wen, cwen, brch, jal, jalr, mret, ecall,
        // e_rfwen, e_wdata, e_cwen, e_ecall, e_redir, e_rpc
        vecs[0] = '{32'h8000_0000, 32'h0, 32'h1234, 32'h0, 32'h0,
                    5'd5, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h3000_0000};
        vecs[1] = '{32'h8000_0004, 32'h0, 32'hdead, 32'h0, 32'h0,
                    5'd0, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 32'hdead, 1'b0, 1'b0, 1'b0, 32'h3000_0000};
        vecs[2] = '{32'h8000_0008, 32'h0, 32'h88, 32'h0, 32'h0,
                    5'd0, 12'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 32'h88, 1'b1, 1'b0, 1'b0, 32'h3000_0000};
        vecs[3] = '{32'h8000_0040, 32'h8000_0044, 32'h0,
                    32'h8000_2000, 32'h8000_1000,
                    5'd0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8000_1000};
        vecs[4] = '{32'h8000_1000, 32'h8000_1004, 32'h0,
                    32'h8000_2000, 32'h8000_1000,
                    5'd0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                    1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_2000};
        vecs[5] = '{32'hFFFF_FFFC, 32'h100, 32'h55, 32'h0, 32'h0,
                    5'd1, 12'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100};
        vecs[6] = '{32'h8000_0100, 32'h8000_0200, 32'h7, 32'h0, 32'h0,
                    5'd3, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 32'h7, 1'b0, 1'b0, 1'b1, 32'h8000_0200};

        clear_in();
        i_ifu_ready = 1'b1;
        reset       = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_redir_valid", {63'd0, o_redirect_valid}, 64'd0);
        chk("rst_redir_pc", {32'd0, o_redirect_pc}, 64'h3000_0000);
        chk("rst_instret", o_instret, 64'd0);
        chk("rst_commit", {63'd0, o_commit}, 64'd0);
        chk("rst_rf_wen", {63'd0, o_rf_wen}, 64'd0);
        chk("rst_rf_wdata", {32'd0, o_rf_wdata}, 64'd0);
        chk("rst_epc", {32'd0, o_epc}, 64'd0);
        chk("rst_commit_pc", {32'd0, o_commit_pc}, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", {63'd0, u_if.ready}, 64'd1);

        for (int i = 0; i < 7; i++) begin
            clear_in();
            u_if.valid    = 1'b1;
            u_if.pc       = vecs[i].pc;
            u_if.pc_next  = vecs[i].pc_next;
            u_if.res      = vecs[i].res;
            u_if.mepc     = vecs[i].mepc;
            u_if.mtvec    = vecs[i].mtvec;
            u_if.rd_addr  = vecs[i].rd;
            u_if.csr_addr = vecs[i].csr;
            u_if.wen      = vecs[i].wen;
            u_if.csr_wen  = vecs[i].cwen;
            u_if.brch     = vecs[i].brch;
            u_if.jal      = vecs[i].jal;
            u_if.jalr     = vecs[i].jalr;
            u_if.mret     = vecs[i].mret;
            u_if.ecall    = vecs[i].ecall;
            @(negedge clock);
            u_if.valid  = 1'b0;
            exp_instret = exp_instret + 64'd1;
            chk($sformatf("v%0d_commit", i), {63'd0, o_commit}, 64'd1);
            chk($sformatf("v%0d_commit_pc", i), {32'd0, o_commit_pc},
                {32'd0, vecs[i].pc});
            chk($sformatf("v%0d_rf_wen", i), {63'd0, o_rf_wen},
                {63'd0, vecs[i].e_rfwen});
            chk($sformatf("v%0d_rf_waddr", i), {59'd0, o_rf_waddr},
                {59'd0, vecs[i].rd});
            chk($sformatf("v%0d_rf_wdata", i), {32'd0, o_rf_wdata},
                {32'd0, vecs[i].e_wdata});
            chk($sformatf("v%0d_csr_wen", i), {63'd0, o_csr_wen},
                {63'd0, vecs[i].e_cwen});
            chk($sformatf("v%0d_csr_waddr", i), {52'd0, o_csr_waddr},
                {52'd0, vecs[i].csr});
            chk($sformatf("v%0d_csr_wdata", i), {32'd0, o_csr_wdata},
                {32'd0, vecs[i].res});
            chk($sformatf("v%0d_ecall", i), {63'd0, o_ecall_commit},
                {63'd0, vecs[i].e_ecall});
            chk($sformatf("v%0d_epc", i), {32'd0, o_epc},
                {32'd0, vecs[i].pc});
            chk($sformatf("v%0d_redir", i), {63'd0, o_redirect_valid},
                {63'd0, vecs[i].e_redir});
            chk($sformatf("v%0d_flush", i), {63'd0, o_flush},
                {63'd0, vecs[i].e_redir});
            chk($sformatf("v%0d_redir_pc", i), {32'd0, o_redirect_pc},
                {32'd0, vecs[i].e_rpc});
            chk($sformatf("v%0d_ready", i), {63'd0, u_if.ready},
                {63'd0, ~vecs[i].e_redir});
            chk($sformatf("v%0d_instret", i), o_instret, exp_instret);
            @(negedge clock);
            chk($sformatf("v%0d_idle_commit", i), {63'd0, o_commit}, 64'd0);
            chk($sformatf("v%0d_idle_redir", i),
                {63'd0, o_redirect_valid}, 64'd0);
        end

        // Back-to-back ALU retires.
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("b2b%0d_ready", k), {63'd0, u_if.ready}, 64'd1);
            drive_alu(32'h8000_0200 + 32'(k * 4), 5'(k + 10),
                      32'h100 + 32'(k));
            @(negedge clock);
            exp_instret = exp_instret + 64'd1;
            chk($sformatf("b2b%0d_commit", k), {63'd0, o_commit}, 64'd1);
            chk($sformatf("b2b%0d_waddr", k), {59'd0, o_rf_waddr},
                64'(k + 10));
            chk($sformatf("b2b%0d_wdata", k), {32'd0, o_rf_wdata},
                64'h100 + 64'(k));
        end
        clear_in();
        chk("b2b_instret", o_instret, exp_instret);
        @(negedge clock);

        // jal with IFU stalling the redirect for three cycles.
        i_ifu_ready = 1'b0;
        clear_in();
        u_if.valid   = 1'b1;
        u_if.jal     = 1'b1;
        u_if.wen     = 1'b1;
        u_if.rd_addr = 5'd1;
        u_if.pc      = 32'h8000_0010;
        u_if.pc_next = 32'h8000_0100;
        @(negedge clock);
        clear_in();
        exp_instret = exp_instret + 64'd1;
        chk("jal_wdata", {32'd0, o_rf_wdata}, 64'h8000_0014);
        chk("jal_flush1", {63'd0, o_flush}, 64'd1);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                chk($sformatf("jal_flush_c%0d", c), {63'd0, o_flush}, 64'd0);
                chk($sformatf("jal_commit_c%0d", c), {63'd0, o_commit},
                    64'd0);
            end
            chk($sformatf("jal_redir_c%0d", c),
                {63'd0, o_redirect_valid}, 64'd1);
            chk($sformatf("jal_rpc_c%0d", c), {32'd0, o_redirect_pc},
                64'h8000_0100);
            chk($sformatf("jal_ready_c%0d", c), {63'd0, u_if.ready}, 64'd0);
            if (c == 4)
                i_ifu_ready = 1'b1;
            @(negedge clock);
        end
        chk("jal_redir_done", {63'd0, o_redirect_valid}, 64'd0);
        chk("jal_ready_done", {63'd0, u_if.ready}, 64'd1);
        chk("jal_instret", o_instret, exp_instret);

        // Reset asserted while holding a redirect.
        i_ifu_ready = 1'b0;
        clear_in();
        u_if.valid   = 1'b1;
        u_if.brch    = 1'b1;
        u_if.pc      = 32'h8000_0300;
        u_if.pc_next = 32'h8000_0400;
        @(negedge clock);
        clear_in();
        @(negedge clock);
        chk("rr_redir_before", {63'd0, o_redirect_valid}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("rr_redir", {63'd0, o_redirect_valid}, 64'd0);
        chk("rr_redir_pc", {32'd0, o_redirect_pc}, 64'h3000_0000);
        chk("rr_instret", o_instret, 64'd0);
        chk("rr_commit", {63'd0, o_commit}, 64'd0);
        exp_instret = 64'd0;
        @(negedge clock);
        reset       = 1'b1;
        i_ifu_ready = 1'b1;
        @(negedge clock);
        chk("rr_ready", {63'd0, u_if.ready}, 64'd1);
        chk("rr_no_write", {63'd0, o_rf_wen}, 64'd0);
        drive_alu(32'h8000_0500, 5'd7, 32'hABCD);
        @(negedge clock);
        clear_in();
        exp_instret = exp_instret + 64'd1;
        chk("rr_commit_after", {63'd0, o_commit}, 64'd1);
        chk("rr_rf_wen_after", {63'd0, o_rf_wen}, 64'd1);
        chk("rr_wdata_after", {32'd0, o_rf_wdata}, 64'hABCD);
        chk("rr_instret_after", o_instret, exp_instret);
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
